// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM states.
// Imported by the ALU control decoder and alu_exec_unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_SLL = 4'd13;
    localparam logic [3:0] ALU_ILL = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL,
        DONE
    } state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational evaluation of the single-cycle ALU ops.
// Unknown codes raise ill_o and produce a zero result.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   ctl_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o,
    output logic         ill_o
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        res_o = '0;
        ovf_o = 1'b0;
        ill_o = 1'b0;
        unique case (ctl_i)
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_ADD: begin
                res_o = sum;
                ovf_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            ALU_SUB: begin
                res_o = diff;
                ovf_o = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            ALU_SLT: res_o = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_NOR: res_o = ~(a_i | b_i);
            default: ill_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with iterative SLL and valid/ready handshakes.
// Define ALU_EXEC_MUL_EN to add the iterative shift-add multiplier (code 3).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    alu_ctl,
    input  logic [W-1:0]  op_a,
    input  logic [W-1:0]  op_b,
    input  logic [SW-1:0] shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic          zero,
    output logic          ovf,
    output logic          illegal
);

    state_e        state_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  res_q;
    logic [SW-1:0] cnt_q;
    logic          zero_q;
    logic          ovf_q;
    logic          ill_q;

    logic [W-1:0]  core_res;
    logic          core_ovf;
    logic          core_ill;
    logic [W-1:0]  shl;
    logic          accept;

    alu_comb_core #(.W(W)) u_core (
        .ctl_i (alu_ctl),
        .a_i   (op_a),
        .b_i   (op_b),
        .res_o (core_res),
        .ovf_o (core_ovf),
        .ill_o (core_ill)
    );

    assign in_ready  = !flush &&
                       (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign shl       = acc_q << 1;
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = ill_q;

`ifdef ALU_EXEC_MUL_EN
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   mcand_q;
    logic [W:0]     psum;
    logic [2*W-1:0] prod_nxt;

    // Low half holds the remaining multiplier bits, high half the partial sum.
    assign psum     = {1'b0, prod_q[2*W-1:W]} +
                      (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    assign prod_nxt = {psum, prod_q[W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
`endif
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            if (state_q == DONE && out_ready) state_q <= IDLE;
            if (accept) begin
                if (alu_ctl == ALU_SLL) begin
                    acc_q <= op_b;
                    cnt_q <= shamt;
                    if (shamt == '0) begin
                        res_q   <= op_b;
                        zero_q  <= (op_b == '0);
                        ovf_q   <= 1'b0;
                        ill_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                else if (alu_ctl == ALU_MUL) begin
                    prod_q  <= {{W{1'b0}}, op_b};
                    mcand_q <= op_a;
                    cnt_q   <= SW'(W-1);
                    state_q <= MUL;
                end
`endif
                else begin
                    res_q   <= core_res;
                    zero_q  <= (core_res == '0);
                    ovf_q   <= core_ovf;
                    ill_q   <= core_ill;
                    state_q <= DONE;
                end
            end
            if (state_q == SHIFT) begin
                acc_q <= shl;
                cnt_q <= cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    res_q   <= shl;
                    zero_q  <= (shl == '0);
                    ovf_q   <= 1'b0;
                    ill_q   <= 1'b0;
                    state_q <= DONE;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            if (state_q == MUL) begin
                prod_q <= prod_nxt;
                cnt_q  <= cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    res_q   <= prod_nxt[W-1:0];
                    zero_q  <= (prod_nxt[W-1:0] == '0);
                    ovf_q   <= |prod_nxt[2*W-1:W];
                    ill_q   <= 1'b0;
                    state_q <= DONE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, random ops, corner sequences.
// Honours ALU_EXEC_MUL_EN when the design is built with it.
module tb_alu_exec_unit;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_ctl = '0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [SW-1:0] shamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          zero;
    logic          ovf;
    logic          illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    ctl;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [SW-1:0] sh;
        logic [W-1:0]  res;
        logic          ovf;
        logic          ill;
        int            lat;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [SW-1:0] s,
                                input logic [W-1:0] r, input logic o,
                                input logic i, input int l);
        vec_t v;
        v.ctl = c; v.a = a; v.b = b; v.sh = s;
        v.res = r; v.ovf = o; v.ill = i; v.lat = l;
        return v;
    endfunction

    // Reference model: plain wide arithmetic on the operation definitions.
    function automatic vec_t model(input logic [3:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SW-1:0] s);
        vec_t v;
        longint sa, sb, sr;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v = mk(c, a, b, s, '0, 1'b0, 1'b0, 1);
        case (c)
            4'd0:  v.res = a & b;
            4'd1:  v.res = a | b;
            4'd2:  begin
                sr = sa + sb;
                v.res = W'(sr);
                v.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd6:  begin
                sr = sa - sb;
                v.res = W'(sr);
                v.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd7:  v.res = (sa < sb) ? 1 : 0;
            4'd12: v.res = ~(a | b);
            4'd13: begin
                v.res = b << s;
                v.lat = (s == 0) ? 1 : int'(s) + 1;
            end
`ifdef ALU_EXEC_MUL_EN
            4'd3:  begin
                p = 64'(a) * 64'(b);
                v.res = p[W-1:0];
                v.ovf = (p[63:32] != 0);
                v.lat = W + 1;
            end
`endif
            default: v.ill = 1'b1;
        endcase
        return v;
    endfunction

    task automatic do_op(input vec_t v, input string nm);
        int n;
        bit busy_ok;
        @(negedge clk);
        out_ready = 1'b1;
        alu_ctl = v.ctl; op_a = v.a; op_b = v.b; shamt = v.sh;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctl = 4'($urandom); op_a = $urandom; op_b = $urandom;
        shamt = SW'($urandom);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end while (!out_valid && n < 100);
        chk({nm, "_latency"}, n, v.lat);
        chk({nm, "_result"}, result, v.res);
        chk({nm, "_zero"}, zero, (v.res == 0));
        chk({nm, "_ovf"}, ovf, v.ovf);
        chk({nm, "_illegal"}, illegal, v.ill);
        chk({nm, "_busy_ready"}, busy_ok, 1);
    endtask

    task automatic no_valid_for(input int cyc, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic [3:0] codes [9];
        logic [W-1:0] edges [4];
        vec_t v;
        logic [3:0] c;
        logic [W-1:0] a, b;

        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd13, 4'd15};
        edges = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

        tbl.push_back(mk(4'd2,  32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1, 0, 1));
        tbl.push_back(mk(4'd6,  32'h1234, 32'h1234, 0, 32'h0, 0, 0, 1));
        tbl.push_back(mk(4'd7,  32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0, 0, 1));
        tbl.push_back(mk(4'd7,  32'h1, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, 1));
        tbl.push_back(mk(4'd13, 32'h0, 32'h3, 4, 32'h30, 0, 0, 5));
        tbl.push_back(mk(4'd13, 32'h5, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 1));
        tbl.push_back(mk(4'd13, 32'h0, 32'h1, 31, 32'h8000_0000, 0, 0, 32));
        tbl.push_back(mk(4'd15, 32'h5, 32'h6, 0, 32'h0, 0, 1, 1));
        tbl.push_back(mk(4'd4,  32'h5, 32'h6, 0, 32'h0, 0, 1, 1));
        tbl.push_back(mk(4'd6,  32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 1, 0, 1));
        tbl.push_back(mk(4'd0,  32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 1));
        tbl.push_back(mk(4'd1,  32'hF0F0, 32'hFF00, 0, 32'hFFF0, 0, 0, 1));
        tbl.push_back(mk(4'd12, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0, 1));
        tbl.push_back(mk(4'd2,  32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0, 0, 1));
`ifdef ALU_EXEC_MUL_EN
        tbl.push_back(mk(4'd3, 32'h7, 32'h6, 0, 32'd42, 0, 0, 33));
        tbl.push_back(mk(4'd3, 32'hFFFF_FFFF, 32'h2, 0, 32'hFFFF_FFFE, 1, 0, 33));
`else
        tbl.push_back(mk(4'd3, 32'h7, 32'h6, 0, 32'h0, 0, 1, 1));
`endif

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < tbl.size(); i++)
            do_op(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: NOR held for three cycles, then pop and push together.
        @(negedge clk);
        out_ready = 1'b0;
        alu_ctl = 4'd12; op_a = '0; op_b = '0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 32'hFFFF_FFFF);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        chk("bp_hold_result", result, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        alu_ctl = 4'd0; op_a = 32'hF0F0; op_b = 32'hFF00; in_valid = 1'b1;
        #1;
        chk("bp_same_cycle_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_and_valid", out_valid, 1);
        chk("bp_and_result", result, 32'hF000);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Flush on the second SHIFT cycle of a long shift.
        @(negedge clk);
        alu_ctl = 4'd13; op_b = 32'h1; shamt = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_ready", in_ready, 1);
        no_valid_for(25, "flush_no_valid");
        do_op(tbl[0], "post_flush");

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        alu_ctl = 4'd13; op_b = 32'h5; shamt = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", zero, 1);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        no_valid_for(25, "mid_rst_no_valid");
        do_op(tbl[1], "post_reset");

        for (int i = 0; i < 150; i++) begin
            int k;
            k = $urandom_range(0, 9);
            c = (k < 9) ? codes[k] : 4'($urandom);
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            v = model(c, a, b, SW'($urandom_range(0, 31)));
            do_op(v, $sformatf("rnd%0d_ctl%0d", i, c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code together with two operands and a shift amount.
- Produces the result plus zero, overflow and illegal flags, using valid/ready handshakes on both sides.
- Logic ops complete in one cycle. Shift-left runs iteratively, one bit per cycle, so the stage has a real FSM and backpressure.

Parameters:
- W, 32, operand/result width in bits.
- SW, $clog2(W), shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous abort; drops any in-flight op.
- in_valid  in  1  request present.
- in_ready  out  1  stage accepts a request this cycle.
- alu_ctl  in  4  operation code from the ALU control decoder.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- shamt  in  SW  shift amount for SLL.
- out_valid  out  1  result registered and pending.
- out_ready  in  1  consumer takes the result.
- result  out  W  operation result.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow; valid for ADD/SUB only, 0 otherwise.
- illegal  out  1  unsupported alu_ctl; result forced to 0.

Behaviour:
- Codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 13 SLL (op_b << shamt).
  - 15 and every other code not listed are illegal.
- SLT is signed; result is {W-1 zeros, (signed a < signed b)}.
- ADD/SUB wrap modulo 2^W. ovf is set on signed overflow (operand signs vs. result sign).
- FSM states:
  - IDLE: no op held.
  - SHIFT: iterating an SLL.
  - MUL: iterating a multiply; exists only with the optional feature.
  - DONE: result held until consumed.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Inputs are sampled only on accept.
- Single-cycle ops and illegal codes: accept in cycle N → DONE with out_valid=1 in cycle N+1.
- SLL:
  - Accept loads an accumulator with op_b and a counter with shamt, then goes to SHIFT.
  - Each SHIFT cycle shifts the accumulator left by 1 and decrements the counter. Exit to DONE when the counter reaches 0.
  - Latency is shamt+1 cycles. shamt=0 skips SHIFT and completes in 1 cycle.
- DONE:
  - result, zero, ovf and illegal stay stable while out_valid && !out_ready.
  - On out_ready with no new accept → IDLE, out_valid=0.
  - On out_ready with a simultaneous accept → the new op starts; back-to-back single-cycle ops sustain 1 op/cycle.
- flush:
  - Has priority over all other events: next state IDLE, out_valid=0, counter cleared.
  - in_ready is 0 during the flush cycle; no accept occurs.
- Reset (rst_n=0, any state, mid-shift included):
  - State returns to IDLE.
  - out_valid=0, result=0, zero=1, ovf=0, illegal=0, counter=0.
  - in_ready reads 1 once rst_n deasserts.
- Outputs are registered; there is no combinational path from inputs to result or flags.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined:
  - Code 3 = MUL, giving the low W bits of unsigned op_a*op_b.
  - Implemented as a shift-add multiplier: state MUL, W iterations, one bit per cycle, so latency is W+1 cycles.
  - ovf = 1 if any high product bit is nonzero.
  - flush and reset abort it as they do SHIFT.
- Undefined: code 3 is illegal, the MUL state and multiplier datapath are absent, and area is reduced.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit localparams for all alu_ctl codes (AND=0, OR=1, ADD=2, MUL=3, SUB=6, SLT=7, NOR=12, SLL=13, ILL=15).
  - The FSM state enum: IDLE, SHIFT, MUL, DONE.
- The ALU control decoder imports the same constants.
- One sub-module, alu_comb_core: pure combinational evaluation of single-cycle ops producing result and ovf. The FSM, iterative shifter and multiplier stay in the top.

Test Plan:
- ADD overflow: op_a=0x7FFFFFFF, op_b=1, alu_ctl=2, out_ready=1 → next cycle result=0x80000000, ovf=1, zero=0.
- SUB to zero: op_a=op_b=0x1234, ctl=6 → result=0, zero=1, ovf=0. Then SLT with a=0xFFFFFFFF, b=1 (ctl=7) → result=1.
- SLL: op_b=0x3, shamt=4, ctl=13 → in_ready=0 for 4 cycles, out_valid on cycle 5, result=0x30. shamt=0 → result=op_b after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles after a NOR of 0,0 → result=0xFFFFFFFF stable, in_ready=0. Raise out_ready with a new AND pending → both handshakes complete in the same cycle.
- Illegal code: ctl=15 → result=0, illegal=1, zero=1 after 1 cycle. ctl=3 → illegal=1 without ALU_EXEC_MUL_EN; with it, 7*6 gives result=42 after 33 cycles.
- Abort: assert flush on SHIFT cycle 2 of a shamt=20 op → IDLE next cycle, out_valid never rises. Repeat with rst_n low mid-shift → all outputs return to reset values immediately.
